// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, its
// next-state function and the table entry layout.
package bp_pkg;

  // Widest PC and tag the entry struct can carry; narrower instances cast into it.
  localparam int BP_PC_W  = 64;
  localparam int BP_TAG_W = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    bp_ctr_e             ctr;
  } bp_entry_t;

  function automatic bp_ctr_e ctr_next(bp_ctr_e c, logic taken);
    bp_ctr_e n;
    n = c;
    case (c)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  n = taken ? STRONG_T : WEAK_T;
      default:   n = WEAK_NT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_cnt32 (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                       cnt <= '0;
    else if (inc && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor with branch/mispredict counters.
// Define BP_GSHARE_EN to XOR a global history register into the read index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 64,
  parameter int ENTRIES   = 64,
  parameter int IDX_WIDTH = 6,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 if_valid,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  output logic [IDX_WIDTH-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [IDX_WIDTH-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 upd_mispredict,
  input  logic                 clear,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispredict_cnt
);

  bp_entry_t tbl [ENTRIES];

  logic [IDX_WIDTH-1:0] base_idx, rd_idx;
  logic [TAG_WIDTH-1:0] rd_tag, up_tag;
  logic                 rd_hit, up_hit;
  logic                 unused_upd_pc;

  assign base_idx      = if_pc[IDX_WIDTH+1:2];
  assign rd_tag        = if_pc[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];
  assign up_tag        = upd_pc[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];
  assign unused_upd_pc = ^upd_pc;

`ifdef BP_GSHARE_EN
  logic [IDX_WIDTH-1:0] ghr;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)       ghr <= '0;
    else if (upd_valid) ghr <= {ghr[IDX_WIDTH-2:0], upd_taken};
  end

  assign rd_idx = base_idx ^ ghr;
`else
  assign rd_idx = base_idx;
`endif

  // Reads see only registered state: a same-cycle update is not bypassed.
  assign rd_hit      = tbl[rd_idx].valid && (tbl[rd_idx].tag == BP_TAG_W'(rd_tag));
  assign pred_taken  = if_valid && rd_hit && tbl[rd_idx].ctr[1];
  assign pred_target = pred_taken ? PC_WIDTH'(tbl[rd_idx].target) : if_pc + PC_WIDTH'(4);
  assign pred_idx    = rd_idx;

  assign up_hit = tbl[upd_idx].valid && (tbl[upd_idx].tag == BP_TAG_W'(up_tag));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].ctr   <= WEAK_NT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        tbl[upd_idx].ctr <= ctr_next(tbl[upd_idx].ctr, upd_taken);
        if (upd_taken) tbl[upd_idx].target <= BP_PC_W'(upd_target);
      end else if (upd_taken) begin
        // Not-taken misses never allocate, so cold branches default to fall-through.
        tbl[upd_idx] <= '{valid: 1'b1, tag: BP_TAG_W'(up_tag),
                          target: BP_PC_W'(upd_target), ctr: WEAK_T};
      end
    end
  end

  bp_sat_cnt32 u_branch_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (upd_valid),
    .cnt     (branch_cnt)
  );

  bp_sat_cnt32 u_mispredict_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (upd_valid && upd_mispredict),
    .cnt     (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor plus clear/reset/gshare sequences.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        if_valid;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_mispredict;
  logic        clear;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .clear          (clear),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic        iv;
    logic [63:0] ipc;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic [63:0] utg;
    logic        um;
    logic        et;
    logic [63:0] etg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [63:0] ipc, logic uv, logic [63:0] upc,
                              logic ut, logic [63:0] utg, logic um,
                              logic et, logic [63:0] etg);
    vec_t v;
    v.iv = iv; v.ipc = ipc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utg = utg; v.um = um; v.et = et; v.etg = etg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_pc = '0; upd_idx = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; clear = 1'b0;
  endtask

  initial begin
    logic [63:0] pc_t;
    reset_b = 1'b0;
    if_valid = 1'b1;
    if_pc = 64'h100;
    idle_inputs();
    #1;
    chk("reset_pred_taken", {63'd0, pred_taken}, 64'd0);
    chk("reset_pred_target", pred_target, 64'h104);
    chk("reset_branch_cnt", {32'd0, branch_cnt}, 64'd0);
    chk("reset_mispredict_cnt", {32'd0, mispredict_cnt}, 64'd0);
    @(negedge clk);
    reset_b = 1'b1;

`ifndef BP_GSHARE_EN
    // Expectations are the prediction seen before the row's own update lands.
    vecs.push_back(mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 1, 64'h40,  1, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 1, 64'h40));
    vecs.push_back(mk(1, 64'h200, 0, 64'h0,   0, 64'h0,   0, 0, 64'h204));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   1, 1, 64'h40));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   0, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   0, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   0, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 1, 64'h40,  1, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 1, 64'h100, 1, 64'h80,  1, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 1, 64'h80));
    vecs.push_back(mk(0, 64'h100, 0, 64'h0,   0, 64'h0,   0, 0, 64'h104));
    vecs.push_back(mk(1, 64'h100, 1, 64'h300, 0, 64'h0,   0, 1, 64'h80));
    vecs.push_back(mk(1, 64'h100, 1, 64'h300, 1, 64'h500, 1, 1, 64'h80));
    vecs.push_back(mk(1, 64'h100, 0, 64'h0,   0, 64'h0,   0, 0, 64'h104));
    vecs.push_back(mk(1, 64'h300, 0, 64'h0,   0, 64'h0,   0, 1, 64'h500));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      if_valid = vecs[i].iv;
      if_pc = vecs[i].ipc;
      upd_valid = vecs[i].uv;
      upd_pc = vecs[i].upc;
      pc_t = vecs[i].upc;
      upd_idx = pc_t[7:2];
      upd_taken = vecs[i].ut;
      upd_target = vecs[i].utg;
      upd_mispredict = vecs[i].um;
      #1;
      pc_t = vecs[i].ipc;
      chk($sformatf("vec%0d_taken", i), {63'd0, pred_taken}, {63'd0, vecs[i].et});
      chk($sformatf("vec%0d_target", i), pred_target, vecs[i].etg);
      chk($sformatf("vec%0d_idx", i), {58'd0, pred_idx}, {58'd0, pc_t[7:2]});
      if (vecs[i].uv) begin
        exp_br++;
        if (vecs[i].um) exp_mp++;
      end
    end
    @(negedge clk);
    idle_inputs();
    if_valid = 1'b1;
    #1;
    chk("table_branch_cnt", {32'd0, branch_cnt}, 64'(exp_br));
    chk("table_mispredict_cnt", {32'd0, mispredict_cnt}, 64'(exp_mp));
`else
    // Alternating outcome at one PC: history separates the two phases.
    for (int i = 0; i < 40; i++) begin
      logic outcome;
      outcome = (i % 2 == 0);
      @(negedge clk);
      if_valid = 1'b1;
      if_pc = 64'h100;
      #1;
      if (i >= 8) chk($sformatf("gshare%0d_taken", i), {63'd0, pred_taken}, {63'd0, outcome});
      upd_valid = 1'b1;
      upd_pc = 64'h100;
      upd_idx = pred_idx;
      upd_taken = outcome;
      upd_target = 64'h40;
      upd_mispredict = (pred_taken != outcome);
      exp_br++;
      if (pred_taken != outcome) exp_mp++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("gshare_branch_cnt", {32'd0, branch_cnt}, 64'(exp_br));
    chk("gshare_mispredict_cnt", {32'd0, mispredict_cnt}, 64'(exp_mp));
`endif

    // Make sure an entry is live, then clear with an update in the same cycle.
    @(negedge clk);
    if_pc = 64'h300;
    upd_valid = 1'b1; upd_pc = 64'h300; upd_idx = pred_idx;
    upd_taken = 1'b1; upd_target = 64'h500;
    exp_br++;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre_clear_taken", {63'd0, pred_taken}, 64'd1);
    chk("pre_clear_target", pred_target, 64'h500);
    clear = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h340; upd_idx = 6'h10;
    upd_taken = 1'b1; upd_target = 64'h900; upd_mispredict = 1'b1;
    exp_br++; exp_mp++;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("clear_taken_300", {63'd0, pred_taken}, 64'd0);
    chk("clear_target_300", pred_target, 64'h304);
    if_pc = 64'h340;
    #1;
    chk("clear_ignored_upd", {63'd0, pred_taken}, 64'd0);
    chk("clear_branch_cnt", {32'd0, branch_cnt}, 64'(exp_br));
    chk("clear_mispredict_cnt", {32'd0, mispredict_cnt}, 64'(exp_mp));

    // Reset landing in the middle of an update cycle discards it.
    @(negedge clk);
    if_pc = 64'h100;
    upd_valid = 1'b1; upd_pc = 64'h100; upd_idx = pred_idx;
    upd_taken = 1'b1; upd_target = 64'h40; upd_mispredict = 1'b1;
    #1;
    reset_b = 1'b0;
    #1;
    chk("async_reset_branch_cnt", {32'd0, branch_cnt}, 64'd0);
    chk("async_reset_mispredict_cnt", {32'd0, mispredict_cnt}, 64'd0);
    @(negedge clk);
    idle_inputs();
    reset_b = 1'b1;
    #1;
    chk("reset_discard_taken", {63'd0, pred_taken}, 64'd0);
    chk("reset_discard_target", pred_target, 64'h104);
    chk("reset_discard_cnt", {32'd0, branch_cnt}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 64, meaning PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 64, meaning predictor table depth (power of two).
REQ-003 SHALL have parameter IDX_WIDTH, default 6, meaning log2(ENTRIES).
REQ-004 SHALL have parameter TAG_WIDTH, default 8, meaning BTB tag width.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port if_valid, input, 1 bit: the IF stage presents a fetch PC.
REQ-008 SHALL have port if_pc, input, PC_WIDTH bits: the fetch PC.
REQ-009 SHALL have port pred_taken, output, 1 bit: predict taken.
REQ-010 SHALL have port pred_target, output, PC_WIDTH bits: predicted next PC.
REQ-011 SHALL have port pred_idx, output, IDX_WIDTH bits: table index used, carried down the pipe.
REQ-012 SHALL have port upd_valid, input, 1 bit: ID stage resolved a conditional branch.
REQ-013 SHALL have port upd_pc, input, PC_WIDTH bits: PC of the resolved branch.
REQ-014 SHALL have port upd_idx, input, IDX_WIDTH bits: pred_idx returned with that branch.
REQ-015 SHALL have port upd_taken, input, 1 bit: actual branch outcome.
REQ-016 SHALL have port upd_target, input, PC_WIDTH bits: resolved branch target.
REQ-017 SHALL have port upd_mispredict, input, 1 bit: the prediction was wrong.
REQ-018 SHALL have port clear, input, 1 bit: synchronous invalidate of all entries.
REQ-019 SHALL have port branch_cnt, output, 32 bits: count of resolved branches.
REQ-020 SHALL have port mispredict_cnt, output, 32 bits: count of mispredictions.

Function
REQ-021 Each entry SHALL hold: valid bit, TAG_WIDTH tag, PC_WIDTH target, 2-bit saturating counter.
REQ-022 The base index SHALL be if_pc[IDX_WIDTH+1:2], and the tag SHALL be if_pc[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2].
REQ-023 Prediction SHALL be combinational from registered state (zero-cycle latency); pred_idx SHALL equal the index used.
REQ-024 A hit SHALL be defined as valid[idx] AND tag match; pred_taken = if_valid AND hit AND ctr[idx][1].
REQ-025 pred_target SHALL be target[idx] when pred_taken, otherwise if_pc+4 (modulo 2^PC_WIDTH).
REQ-026 On upd_valid, ctr[upd_idx] SHALL increment on taken and decrement on not-taken, saturating at 3 and 0.
REQ-027 On upd_valid with upd_taken and a miss at upd_idx (invalid entry or tag mismatch): allocate the entry: valid=1, tag from upd_pc, target=upd_target, ctr=2 (weak taken).
REQ-028 On upd_valid with upd_taken and a hit, the target SHALL be overwritten with upd_target.
REQ-029 On upd_valid with not-taken and a miss, no allocation SHALL occur and the counter SHALL be left untouched.
REQ-030 A same-cycle read and update of one index SHALL return pre-update state (no bypass).
REQ-031 branch_cnt SHALL increment on each upd_valid; mispredict_cnt SHALL increment on each upd_valid AND upd_mispredict; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 clear SHALL zero all valid bits and set all counters to 1 on the next edge; an upd_valid in the same cycle SHALL be ignored for the table but still counted.

Reset
REQ-033 On reset_b low, asynchronously: all valid bits 0, counters 2'b01, GHR 0, branch_cnt 0, mispredict_cnt 0; outputs therefore pred_taken=0 and pred_target=if_pc+4.
REQ-034 A reset asserted mid-update SHALL discard that update entirely.

Configuration
REQ-035 Macro BP_GSHARE_EN defined: an IDX_WIDTH-bit global history register SHALL be maintained; prediction index = base index XOR GHR; on upd_valid, GHR <= {GHR[IDX_WIDTH-2:0], upd_taken}; tag and update continue to use upd_idx.
REQ-036 Macro BP_GSHARE_EN undefined: no GHR SHALL exist, and index = base index.

Structure
REQ-037 Package bp_pkg SHALL hold the counter enum (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11), the counter next-state function and the entry struct typedef.
REQ-038 Sub-module bp_sat_cnt32 (saturating 32-bit event counter) SHALL be instantiated twice.

Verification
REQ-039 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, both counters 0.
REQ-040 upd_valid, upd_pc=0x100, taken, target=0x40 -> next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x40.
REQ-041 Three not-taken updates at 0x100 -> counter 0, pred_taken=0; a fourth not-taken keeps it at 0.
REQ-042 Aliasing: allocate at 0x100, then if_pc=0x100+(ENTRIES*4) -> tag miss, pred_taken=0.
REQ-043 clear with simultaneous upd_valid+upd_mispredict -> all entries invalid, branch_cnt and mispredict_cnt each +1.
REQ-044 With BP_GSHARE_EN, alternating taken/not-taken at a single PC -> after warm-up, prediction matches the outcome every time.
